// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, instruction field layout and sequencer states
package cpu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PC_W   = 8;

    // Opcode values are shared with the alu block, which decodes the same constants.
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_BZ   = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RD_MSB   = 12;
    localparam int RD_LSB   = 10;
    localparam int RS_MSB   = 9;
    localparam int RS_LSB   = 7;
    localparam int RT_MSB   = 6;
    localparam int RT_LSB   = 4;
    localparam int IMM7_W   = 7;
    localparam int IMM10_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_e;

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 8-entry register file, r0 hardwired to zero, one write port
module reg_file
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        ra_addr,
    input  logic [2:0]        rb_addr,
    input  logic [2:0]        dbg_addr,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != 3'd0)) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data  = (ra_addr  == 3'd0) ? '0 : regs_q[ra_addr];
    assign rb_data  = (rb_addr  == 3'd0) ? '0 : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute/writeback sequencer driving the ALU
module control_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PC_W   = DEF_PC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              halted,
    input  logic [2:0]        dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [2:0]        alu_op_q, alu_op_d;
    logic [DATA_W-1:0] wb_q, wb_d;
    logic              zero_q, zero_d;
    logic              rf_we;

    logic [2:0]        op, rd, rs, rt;
    logic [DATA_W-1:0] rs_data, rt_data, imm7_sext;
    logic [PC_W-1:0]   br_off;
    logic              is_alu_op;

    assign op        = ir_q[OP_MSB:OP_LSB];
    assign rd        = ir_q[RD_MSB:RD_LSB];
    assign rs        = ir_q[RS_MSB:RS_LSB];
    assign rt        = ir_q[RT_MSB:RT_LSB];
    assign imm7_sext = {{(DATA_W-IMM7_W){ir_q[IMM7_W-1]}}, ir_q[IMM7_W-1:0]};
    assign br_off    = PC_W'($signed(ir_q[IMM10_W-1:0]));
    assign is_alu_op = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUBI);

    reg_file #(.DATA_W(DATA_W)) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (rs),
        .rb_addr  (rt),
        .dbg_addr (dbg_raddr),
        .wr_en    (rf_we),
        .wr_addr  (rd),
        .wr_data  (wb_q),
        .ra_data  (rs_data),
        .rb_data  (rt_data),
        .dbg_data (dbg_rdata)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        wb_d     = wb_q;
        zero_d   = zero_q;
        rf_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU operands are only refreshed for ALU ops so the ALU inputs stay quiet otherwise.
                if (is_alu_op) begin
                    alu_a_d  = rs_data;
                    alu_b_d  = (op == OP_ADD) ? rt_data : imm7_sext;
                    alu_op_d = op;
                    state_d  = S_EXECUTE;
                end else if (op == OP_BZ) begin
                    state_d = S_EXECUTE;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                if (is_alu_op) begin
                    wb_d    = alu_result;
                    zero_d  = alu_zero;
                    state_d = S_WRITEBACK;
                end else begin
                    if (zero_q) pc_d = pc_q + br_off;
                    state_d = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            wb_q     <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            wb_q     <= wb_d;
            zero_q   <= zero_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign halted     = (state_q == S_HALT);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench with ISA-level reference model for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_zero;
    logic        halted;
    logic [2:0]  dbg_raddr = '0;
    logic [15:0] dbg_rdata;

    always #5 clk = ~clk;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .halted     (halted),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    // Behavioural ALU on the far side of the interface.
    always_comb begin
        alu_result = (alu_opcode == 3'b010) ? alu_a - alu_b : alu_a + alu_b;
        alu_zero   = (alu_result == 16'h0000);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
    } alu_exp_t;

    logic [15:0] mem [256];
    logic [7:0]  fetch_q [$];
    alu_exp_t    alu_q [$];
    logic [15:0] mregs [8];
    int          model_cycles;
    int          checks = 0;
    int          errors = 0;
    int          wmode = 0;
    bit          spurious = 0;
    bit          mon_en = 0;
    int          total_wait = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [6:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 4'b0000};
    endfunction

    function automatic logic [15:0] enc_bz(input logic [9:0] imm);
        return {3'b011, 3'b000, imm};
    endfunction

    localparam logic [15:0] HALT_W = 16'hE000;

    // ISA-level interpreter: records the fetch trace, ALU operand triples, final registers and cycle cost.
    function automatic bit run_model();
        logic [7:0]  pc = 8'd0;
        bit          zf = 0;
        int          steps = 0;
        logic [15:0] ins, a, b, res;
        logic [2:0]  op, rd, rs, rt;
        alu_exp_t    e;
        for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
        model_cycles = 0;
        fetch_q.delete();
        alu_q.delete();
        forever begin
            fetch_q.push_back(pc);
            ins = mem[pc];
            pc  = pc + 8'd1;
            op  = ins[15:13]; rd = ins[12:10]; rs = ins[9:7]; rt = ins[6:4];
            if (op <= 3'd2) begin
                a = mregs[rs];
                b = (op == 3'd0) ? mregs[rt] : {{9{ins[6]}}, ins[6:0]};
                res = (op == 3'd2) ? a - b : a + b;
                e.a = a; e.b = b; e.op = op;
                alu_q.push_back(e);
                zf = (res == 16'h0000);
                if (rd != 3'd0) mregs[rd] = res;
                model_cycles += 4;
            end else if (op == 3'd3) begin
                if (zf) pc = pc + ins[7:0];
                model_cycles += 3;
            end else if (op == 3'd7) begin
                model_cycles += 2;
                return 1;
            end else begin
                model_cycles += 2;
            end
            steps++;
            if (steps > 150) return 0;
        end
    endfunction

    // Instruction memory responder with configurable wait states and spurious acks outside FETCH.
    initial begin
        bit in_fetch = 0;
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (!imem_req) begin
                in_fetch   = 0;
                imem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = 16'($urandom);
            end else begin
                if (!in_fetch) begin
                    in_fetch = 1;
                    wcnt = (wmode == 0) ? 0 : (wmode == 1) ? 3 : $urandom_range(0, 3);
                    total_wait += wcnt;
                end
                if (wcnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 16'($urandom);
                    wcnt--;
                end
            end
        end
    end

    // Monitor: pops expected fetch addresses on each handshake and expected ALU operands in EXECUTE.
    initial begin
        bit         prev_req = 0;
        logic [7:0] prev_addr = '0;
        int         exec_in = 0;
        alu_exp_t   e;
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en) begin
                prev_req = 0;
                exec_in  = 0;
                continue;
            end
            if (exec_in > 0) begin
                exec_in--;
                if (exec_in == 0) begin
                    if (alu_q.size() == 0) begin
                        chk("alu_unexpected", 32'(alu_q.size()), 32'd1);
                    end else begin
                        e = alu_q.pop_front();
                        chk("alu_a", 32'(alu_a), 32'(e.a));
                        chk("alu_b", 32'(alu_b), 32'(e.b));
                        chk("alu_opcode", 32'(alu_opcode), 32'(e.op));
                    end
                end
            end
            if (imem_req) begin
                if (prev_req) chk("imem_addr_stable", 32'(imem_addr), 32'(prev_addr));
                prev_req  = 1;
                prev_addr = imem_addr;
                if (imem_ack) begin
                    prev_req = 0;
                    if (fetch_q.size() == 0) begin
                        chk("fetch_unexpected", 32'(fetch_q.size()), 32'd1);
                    end else begin
                        chk("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
                    end
                    if (mem[imem_addr][15:13] <= 3'd2) exec_in = 2;
                end
            end else begin
                prev_req = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_reg(input string nm, input logic [2:0] r, input logic [15:0] exp);
        dbg_raddr = r;
        #1;
        chk(nm, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic run_program(input int wm, input bit sp);
        int cycles = 0;
        mon_en = 0;
        wmode = wm;
        spurious = sp;
        do_reset();
        void'(run_model());
        total_wait = 0;
        mon_en = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!halted && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        chk("halted", 32'(halted), 32'd1);
        chk("cycles", 32'(cycles), 32'(model_cycles + total_wait));
        chk("fetch_pending", 32'(fetch_q.size()), 32'd0);
        chk("alu_pending", 32'(alu_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) chk_reg("reg", 3'(i), mregs[i]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("req_after_halt", 32'(imem_req), 32'd0);
        chk("stay_halted", 32'(halted), 32'd1);
        mon_en = 0;
    endtask

    task automatic load(input logic [15:0] prog [$]);
        for (int i = 0; i < 256; i++) mem[i] = HALT_W;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    task automatic gen_random();
        int len;
        int k;
        bit ok = 0;
        while (!ok) begin
            len = $urandom_range(6, 14);
            for (int i = 0; i < 256; i++) mem[i] = HALT_W;
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(0, 9);
                if (k <= 5 || k == 9)
                    mem[i] = {3'(k % 3), 13'($urandom)};
                else if (k <= 7)
                    mem[i] = {3'b011, 3'($urandom), 10'($urandom_range(0, 6) - 2)};
                else
                    mem[i] = {3'($urandom_range(4, 6)), 13'($urandom)};
            end
            ok = run_model();
        end
    endtask

    initial begin
        logic [15:0] p1 [$];
        logic [15:0] p2 [$];
        logic [15:0] p3 [$];
        logic [15:0] p4 [$];
        logic [15:0] p5 [$];

        p1 = {enc_i(3'd1, 3'd1, 3'd0, 7'd10), enc_i(3'd1, 3'd2, 3'd0, 7'd20),
              enc_r(3'd0, 3'd3, 3'd1, 3'd2), HALT_W};
        p2 = {enc_i(3'd2, 3'd4, 3'd0, 7'd25), enc_i(3'd1, 3'd5, 3'd0, 7'h40),
              enc_bz(10'd1), enc_i(3'd1, 3'd7, 3'd0, 7'd1), HALT_W};
        p3 = {enc_i(3'd1, 3'd1, 3'd0, 7'd10), enc_i(3'd2, 3'd6, 3'd1, 7'd10),
              enc_bz(10'd1), enc_i(3'd1, 3'd7, 3'd0, 7'd1), HALT_W};
        p4 = {enc_i(3'd1, 3'd1, 3'd0, 7'd10), enc_i(3'd2, 3'd6, 3'd1, 7'd9),
              enc_bz(10'd1), enc_i(3'd1, 3'd7, 3'd0, 7'd1), HALT_W};
        p5 = {enc_i(3'd1, 3'd0, 3'd0, 7'd5), 16'hA5A5, enc_i(3'd1, 3'd2, 3'd0, 7'd3), HALT_W};

        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req", 32'(imem_req), 32'd0);

        load(p1);
        run_program(0, 0);
        chk_reg("p1_r3", 3'd3, 16'd30);

        load(p2);
        run_program(0, 1);
        chk_reg("p2_r4", 3'd4, 16'hFFE7);
        chk_reg("p2_r5", 3'd5, 16'hFFC0);
        chk_reg("p2_r7_nz", 3'd7, 16'd1);

        load(p3);
        run_program(0, 0);
        chk_reg("p3_r6", 3'd6, 16'd0);
        chk_reg("p3_r7_skipped", 3'd7, 16'd0);

        load(p4);
        run_program(2, 1);
        chk_reg("p4_r7", 3'd7, 16'd1);

        load(p1);
        run_program(1, 1);

        load(p5);
        run_program(0, 1);
        chk_reg("p5_r0", 3'd0, 16'd0);
        chk_reg("p5_r2", 3'd2, 16'd3);

        // Asynchronous reset while waiting in FETCH.
        load(p1);
        mon_en = 0;
        wmode = 1;
        spurious = 0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midfetch_req_before", 32'(imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midfetch_req_drop", 32'(imem_req), 32'd0);
        chk("midfetch_addr", 32'(imem_addr), 32'd0);
        chk("midfetch_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in WRITEBACK of ADDI r1,r0,10.
        wmode = 0;
        do_reset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wb_alu_b_before", 32'(alu_b), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("wb_rst_alu_b", 32'(alu_b), 32'd0);
        chk("wb_rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("wb_rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_reg("wb_rst_r1", 3'd1, 16'd0);
        rst_n = 1'b1;
        run_program(0, 0);
        chk_reg("rerun_r3", 3'd3, 16'd30);

        for (int n = 0; n < 20; n++) begin
            gen_random();
            run_program(2, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
